// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings, the default operand width and the sizing rule for the
// iteration counter.
package seq_restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold the value WIDTH itself, hence one extra bit.
  function automatic int count_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: subtract the divisor from the shifted
// partial remainder and keep the difference only if it did not go negative.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and WIDTH+1 bits suffice to see the sign of
  // the trial difference. When the trial is negative the top shifted bit is
  // necessarily zero, so the low WIDTH bits are the kept remainder.
  always_comb begin
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider producing one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands,
// truncating division). Without it the divider is purely unsigned.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] next_quo;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;

  // Operands enter the unsigned core as magnitudes; the signs are applied
  // again only when the result is committed.
  always_comb begin
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;
  end

  // Quotient is negative when the signs differ; the remainder follows the
  // dividend. Most-negative / -1 falls out naturally as most-negative, rem 0.
  always_comb begin
    res_q = (a_neg ^ b_neg) ? -next_quo : next_quo;
    res_r = a_neg ? -step_rem : step_rem;
  end
`else
  // Unsigned build: operands feed the core directly.
  always_comb begin
    a_mag = A;
    b_mag = B;
    res_q = next_quo;
    res_r = step_rem;
  end
`endif

  // Shift the next dividend bit into the remainder and collect the new
  // quotient bit at the bottom of the dividend register.
  always_comb begin
    next_quo = {quo[WIDTH-2:0], step_bit};
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .shifted (({rem, quo[WIDTH-1]})),
    .divisor (divisor),
    .next_rem(step_rem),
    .q_bit   (step_bit)
  );

  // Control FSM and datapath registers; results are only written when the
  // machine enters DONE so they hold steady between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      dz      <= 1'b0;
`ifdef DIV_SIGNED_EN
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            divisor <= b_mag;
            quo     <= a_mag;
            rem     <= '0;
            count   <= CW'(WIDTH);
            busy    <= 1'b1;
            dz      <= 1'b0;
`ifdef DIV_SIGNED_EN
            a_neg   <= A[WIDTH-1];
            b_neg   <= B[WIDTH-1];
`endif
            if (B == '0) begin
              state <= DONE;
              done  <= 1'b1;
              Q     <= '1;
              R     <= A;
              dz    <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= step_rem;
          quo   <= next_quo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            Q     <= res_q;
            R     <= res_r;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8). Expected results
// come from plain integer division; honours DIV_SIGNED_EN when defined.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         dz;

  int assertions;
  int failures;

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .dz   (dz)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  // Reference division computed with ordinary integer arithmetic.
  task automatic modelDivide(input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] q, output logic [W-1:0] r,
                             output logic z);
    int ia, ib, iq, ir;
`ifdef DIV_SIGNED_EN
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    ia = sa;
    ib = sb;
`else
    ia = int'(a);
    ib = int'(b);
`endif
    if (ib == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      q  = W'(iq);
      r  = W'(ir);
      z  = 1'b0;
    end
  endtask

  // Issue one start pulse with the given operands, returning just after E0.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full operation: start, wait (bounded) for done, check latency, results,
  // strobe width and return to idle. Optionally pulses start mid-operation.
  task automatic runDivision(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit inject);
    logic [W-1:0] eq, er;
    logic         ez;
    int           k;
    int           lat;
    modelDivide(a, b, eq, er, ez);
    lat = (b == '0) ? 0 : W;
    applyStimulus(a, b);
    checkOutput("busy_after_start", busy, 1'b1);
    k = 0;
    while (!done && k < 40) begin
      start = (inject && (k == 3)) ? 1'b1 : 1'b0;
      A = W'($urandom);
      B = W'($urandom);
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("done_latency", k, lat);
    checkOutput("busy_with_done", busy, 1'b1);
    checkOutput("quotient", Q, eq);
    checkOutput("remainder", R, er);
    checkOutput("dz_flag", dz, ez);
    start = inject ? 1'b1 : 1'b0;
    A = W'($urandom);
    B = W'($urandom | 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done_one_cycle", done, 1'b0);
    checkOutput("busy_released", busy, 1'b0);
    if (inject) begin
      @(posedge clk);
      #1;
      checkOutput("no_queued_start", busy, 1'b0);
      checkOutput("hold_q_after_ignored", Q, eq);
    end
  endtask

  initial begin
    logic [W-1:0] eq, er, ra, rb;
    logic         ez;
    int           done_seen;
    assertions = 0;
    failures   = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_q", Q, '0);
    checkOutput("reset_r", R, '0);
    checkOutput("reset_dz", dz, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed divisions");
`ifdef DIV_SIGNED_EN
    runDivision(8'h9C, 8'd7, 1'b0);
    runDivision(8'h80, 8'hFF, 1'b0);
    runDivision(8'd100, 8'hF9, 1'b0);
`endif
    runDivision(8'd100, 8'd7, 1'b0);
    runDivision(8'd5, 8'd9, 1'b0);
    runDivision(8'd127, 8'd1, 1'b0);
    runDivision(8'd77, 8'd0, 1'b0);
    runDivision(8'd100, 8'd10, 1'b0);

    // Results must hold while idle even as operands wiggle.
    modelDivide(8'd100, 8'd10, eq, er, ez);
    repeat (3) begin
      A = W'($urandom);
      B = W'($urandom);
      @(posedge clk);
      #1;
    end
    checkOutput("hold_q_idle", Q, eq);
    checkOutput("hold_r_idle", R, er);

    $display("[TB] start ignored while busy");
    runDivision(8'd120, 8'd7, 1'b1);

    $display("[TB] reset during operation");
    applyStimulus(8'd120, 8'd7);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_q", Q, '0);
    checkOutput("midrst_r", R, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("midrst_no_done", done_seen, 0);
    runDivision(8'd99, 8'd4, 1'b0);

    $display("[TB] randomized divisions");
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
      runDivision(ra, rb, 1'b0);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential radix-2 restoring divider for the arithmetic library; the inverse operation to the Wallace-tree multiplier datapath.
- Accepts an unsigned dividend/divisor pair on a start pulse and produces one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done strobe, for use by the divide path next to the multiplier.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- busy  output  1  high from the edge that accepts start until the edge that leaves DONE.
- done  output  1  single-cycle strobe; Q/R are valid while it is high.
- Q  output  WIDTH  quotient.
- R  output  WIDTH  remainder.
- dz  output  1  divide-by-zero flag; valid with done, held until the next accepted start.

Behaviour:
- Interface is fixed: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state): state=IDLE, busy=0, done=0, dz=0, Q=0, R=0, internal registers cleared. Reset asserted mid-operation aborts the division with no done.
- FSM states:
  - IDLE: start=1 at edge E0 latches A and B, clears the partial remainder, sets count=WIDTH and busy=1. If B==0, go to DONE; otherwise go to RUN.
  - RUN: each edge shifts {rem,quo} left by 1 with the next dividend MSB entering. trial = rem - divisor, computed WIDTH+1 bits wide. If trial is non-negative, rem=trial and quotient bit=1; else rem is kept and bit=0. count decrements. After the iteration where count reaches 0 (edge E_WIDTH), go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE at the next edge with busy=0.
- Latency: done is high in the cycle after edge E_WIDTH (WIDTH cycles after start is sampled). For divide-by-zero, done is high in the cycle after E0.
- Divide by zero: Q = all ones, R = A, dz=1.
- Q, R and dz hold their values after done until the next accepted start. They update only on entry to DONE.
- start while busy (RUN or DONE) is ignored with no queuing. start in the same cycle done is high is also ignored.
- Operands are sampled only at the accepting edge; later changes on A and B have no effect.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: A and B are two's complement.
  - IDLE converts both to magnitudes, and the unsigned core runs unchanged.
  - On entry to DONE: Q is negated if signs differ; R takes the dividend's sign (truncating division).
  - Overflow case, most-negative divided by -1: Q = most-negative, R = 0, dz = 0.
  - Divide by zero: Q = all ones, R = A, dz = 1.
  - Latency is unchanged.
- Undefined: purely unsigned. No sign logic is synthesized.

Decomposition:
- Shared header div_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH;
  - the width of the count register, $clog2(WIDTH)+1.
- One natural combinational sub-module, div_step: input is the shifted partial remainder and the divisor; outputs are the next remainder and the quotient bit. It is instantiated once inside the RUN datapath.

Test Plan:
- WIDTH=8, A=200, B=7, start -> busy for 9 cycles; done in cycle 8 after start with Q=28, R=4, dz=0.
- A=5, B=9 -> Q=0, R=5. Then A=255, B=1 -> Q=255, R=0. Also check back-to-back starts issued the cycle after done.
- A=77, B=0 -> done 1 cycle after start, Q=8'hFF, R=77, dz=1. The next valid division clears dz.
- start pulsed again at RUN cycles 3 and 8 with different A/B -> ignored; results match the first operands only.
- rst asserted at RUN cycle 4 -> outputs immediately 0, state IDLE, no done. A new start afterwards completes normally.
- DIV_SIGNED_EN defined:
  - A=-100 (8'h9C), B=7 -> Q=-14 (8'hF2), R=-2 (8'hFE).
  - A=8'h80, B=8'hFF -> Q=8'h80, R=0, dz=0.
